// File: rtl/csr_access_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : csr_access_ctrl_pkg
// Description : Shared types and constants for the CSR access controller.
//               Holds the csr_ctrl command encodings, SYSTEM funct3 codes,
//               the controller FSM state enum and the machine CSR addresses.
// Revision    : 1.0 - initial release
// ============================================================================
package csr_access_ctrl_pkg;

   // Command presented to the CSR file alongside csr_wen
   typedef enum logic [2:0] {
      CTRL_NONE   = 3'b000,
      CTRL_MRET   = 3'b001,
      CTRL_ECALL  = 3'b010,
      CTRL_EBREAK = 3'b011,
      CTRL_CSRW   = 3'b100
   } csr_ctrl_e;

   // SYSTEM-opcode funct3 codes
   localparam logic [2:0] c_f3_priv   = 3'b000;
   localparam logic [2:0] c_f3_csrrw  = 3'b001;
   localparam logic [2:0] c_f3_csrrs  = 3'b010;
   localparam logic [2:0] c_f3_csrrc  = 3'b011;
   localparam logic [2:0] c_f3_csrrwi = 3'b101;
   localparam logic [2:0] c_f3_csrrsi = 3'b110;
   localparam logic [2:0] c_f3_csrrci = 3'b111;

   // Machine-mode CSR addresses
   localparam logic [11:0] c_csr_mstatus = 12'h300;
   localparam logic [11:0] c_csr_mtvec   = 12'h305;
   localparam logic [11:0] c_csr_mepc    = 12'h341;
   localparam logic [11:0] c_csr_mcause  = 12'h342;

   // instruction[31:20] values that select the privileged funct3=000 ops
   localparam logic [11:0] c_sys_ecall  = 12'h000;
   localparam logic [11:0] c_sys_ebreak = 12'h001;
   localparam logic [11:0] c_sys_mret   = 12'h302;

   // Controller FSM states
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CSR_RD = 3'd1,
      ST_CSR_WR = 3'd2,
      ST_TRAP_E = 3'd3,
      ST_TRAP_M = 3'd4,
      ST_BRK    = 3'd5,
      ST_DONE   = 3'd6,
      ST_HALT   = 3'd7
   } state_e;

   // Zicsr ops have funct3[1:0] != 0; funct3 000/100 are not register ops
   function automatic logic is_csr_op(input logic [2:0] f3);
      return (f3[1:0] != 2'b00);
   endfunction

endpackage
`default_nettype wire

// File: rtl/csr_access_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : csr_access_ctrl_if
// Description : Bus bundle of the CSR access controller: IDU request
//               handshake, CSR file transaction/return, WBU result handshake
//               and PC redirect.
//               master : the controller (drives in_ready, csr_*, results)
//               slave  : the surrounding pipeline / CSR file
// Revision    : 1.0 - initial release
// ============================================================================
interface csr_access_ctrl_if
   import csr_access_ctrl_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int CSR_AW = 12
);
   // IDU request
   logic              in_valid;
   logic              in_ready;
   logic [2:0]        in_funct3;
   logic [CSR_AW-1:0] in_csr_addr;
   logic [XLEN-1:0]   in_rs1_data;
   logic [4:0]        in_zimm;
   logic [4:0]        in_rd;
   logic [XLEN-1:0]   in_pc;
   // CSR file transaction
   logic [2:0]        csr_ctrl;
   logic [CSR_AW-1:0] csr_addr;
   logic [XLEN-1:0]   csr_wdata;
   logic [XLEN-1:0]   csr_pc;
   logic              csr_wen;
   logic [XLEN-1:0]   csr_rdata;
   logic [XLEN-1:0]   csr_upc;
   // WBU result and redirect
   logic              out_valid;
   logic              out_ready;
   logic              rd_wen;
   logic [XLEN-1:0]   rd_data;
   logic              redir_valid;
   logic [XLEN-1:0]   redir_pc;

   modport master (
      input  in_valid, in_funct3, in_csr_addr, in_rs1_data, in_zimm, in_rd, in_pc,
      output in_ready,
      output csr_ctrl, csr_addr, csr_wdata, csr_pc, csr_wen,
      input  csr_rdata, csr_upc,
      output out_valid, rd_wen, rd_data, redir_valid, redir_pc,
      input  out_ready
   );

   modport slave (
      output in_valid, in_funct3, in_csr_addr, in_rs1_data, in_zimm, in_rd, in_pc,
      input  in_ready,
      input  csr_ctrl, csr_addr, csr_wdata, csr_pc, csr_wen,
      output csr_rdata, csr_upc,
      input  out_valid, rd_wen, rd_data, redir_valid, redir_pc,
      output out_ready
   );
endinterface
`default_nettype wire

// File: rtl/csr_access_ctrl_alu.sv
`default_nettype none
// ============================================================================
// Module      : csr_alu
// Description : Combinational read-modify-write for Zicsr ops.
//               i_funct3   : instruction funct3 (bit 2 selects immediate)
//               i_rs1_data : rs1 value (register forms)
//               i_zimm     : rs1 field; immediate or rs1 index
//               i_old      : current CSR value
//               o_new_val  : value to write back
//               o_wr_need  : a CSR write must be issued
// Revision    : 1.0 - initial release
// ============================================================================
module csr_alu
   import csr_access_ctrl_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]      i_funct3,
   input  logic [XLEN-1:0] i_rs1_data,
   input  logic [4:0]      i_zimm,
   input  logic [XLEN-1:0] i_old,
   output logic [XLEN-1:0] o_new_val,
   output logic            o_wr_need
);
   logic [XLEN-1:0] w_src;

   always_comb begin
      w_src     = i_funct3[2] ? {{(XLEN-5){1'b0}}, i_zimm} : i_rs1_data;
      o_new_val = i_old;
      o_wr_need = 1'b0;
      case (i_funct3[1:0])
         2'b01: begin
            o_new_val = w_src;
            o_wr_need = 1'b1;
         end
         // Set/clear with a zero rs1 index or zero immediate are pure reads;
         // both cases show up as a zero rs1 field.
         2'b10: begin
            o_new_val = i_old | w_src;
            o_wr_need = (i_zimm != 5'd0);
         end
         2'b11: begin
            o_new_val = i_old & ~w_src;
            o_wr_need = (i_zimm != 5'd0);
         end
         default: ;
      endcase
   end
endmodule
`default_nettype wire

// File: rtl/csr_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : csr_access_ctrl
// Description : EXU-side initiator of the CSR file interface. Accepts one
//               SYSTEM instruction at a time from the IDU, sequences it into
//               CSR file transactions and returns the old CSR value for rd
//               plus a PC redirect for ECALL/MRET.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : csr_access_ctrl_if.master (IDU, CSR file, WBU signals)
//   halt       : only with CSR_EBREAK_HALT_EN; set by EBREAK until reset
// Build option: CSR_EBREAK_HALT_EN - EBREAK halts the controller.
// Revision    : 1.0 - initial release
// ============================================================================
module csr_access_ctrl
   import csr_access_ctrl_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int CSR_AW = 12
) (
   input  logic               clk,
   input  logic               rst_n,
   csr_access_ctrl_if.master  bus
`ifdef CSR_EBREAK_HALT_EN
   ,
   output logic               halt
`endif
);
   state_e            r_state;
   state_e            w_state_next;
   csr_ctrl_e         r_csr_ctrl;
   csr_ctrl_e         w_ctrl_next;
   logic              r_csr_wen;
   logic              w_wen_next;

   logic [2:0]        r_funct3;
   logic [CSR_AW-1:0] r_addr;
   logic [XLEN-1:0]   r_rs1;
   logic [4:0]        r_zimm;
   logic [4:0]        r_rd;
   logic [XLEN-1:0]   r_pc;
   logic [XLEN-1:0]   r_old;
   logic [XLEN-1:0]   r_wdata;
   logic [XLEN-1:0]   r_redir_pc;
   logic              r_is_csr;
   logic              r_is_trap;

   logic [XLEN-1:0]   w_alu_new;
   logic              w_alu_wr_need;
   logic              w_is_priv;

   assign w_is_priv = (bus.in_funct3 == c_f3_priv);

   csr_alu #(.XLEN(XLEN)) u_alu (
      .i_funct3   (r_funct3),
      .i_rs1_data (r_rs1),
      .i_zimm     (r_zimm),
      .i_old      (bus.csr_rdata),
      .o_new_val  (w_alu_new),
      .o_wr_need  (w_alu_wr_need)
   );

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_csr_ctrl <= CTRL_NONE;
         r_csr_wen  <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_csr_ctrl <= w_ctrl_next;
         r_csr_wen  <= w_wen_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (bus.in_valid) begin
               if (w_is_priv && bus.in_csr_addr == CSR_AW'(c_sys_ecall))
                  w_state_next = ST_TRAP_E;
               else if (w_is_priv && bus.in_csr_addr == CSR_AW'(c_sys_mret))
                  w_state_next = ST_TRAP_M;
               else if (w_is_priv && bus.in_csr_addr == CSR_AW'(c_sys_ebreak))
                  w_state_next = ST_BRK;
               else
                  w_state_next = ST_CSR_RD;
            end
         end
         ST_CSR_RD: w_state_next = w_alu_wr_need ? ST_CSR_WR : ST_DONE;
         ST_CSR_WR: w_state_next = ST_DONE;
         ST_TRAP_E: w_state_next = ST_DONE;
         ST_TRAP_M: w_state_next = ST_DONE;
`ifdef CSR_EBREAK_HALT_EN
         ST_BRK:    w_state_next = ST_HALT;
`else
         ST_BRK:    w_state_next = ST_DONE;
`endif
         ST_DONE:   if (bus.out_ready) w_state_next = ST_IDLE;
         ST_HALT:   w_state_next = ST_HALT;
         default:   w_state_next = ST_IDLE;
      endcase
   end

   // csr_ctrl/csr_wen are decoded from the next state and registered so they
   // are glitch-free and line up exactly with the state they belong to. Every
   // state that strobes is left after one cycle, so the strobe is one cycle.
   always_comb begin
      w_ctrl_next = CTRL_NONE;
      w_wen_next  = 1'b0;
      case (w_state_next)
         ST_CSR_WR: begin
            w_ctrl_next = CTRL_CSRW;
            w_wen_next  = 1'b1;
         end
         ST_TRAP_E: begin
            w_ctrl_next = CTRL_ECALL;
            w_wen_next  = 1'b1;
         end
         ST_TRAP_M: w_ctrl_next = CTRL_MRET;
         ST_BRK:    w_ctrl_next = CTRL_EBREAK;
         default: ;
      endcase
   end

   // ----------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_funct3   <= 3'd0;
         r_addr     <= '0;
         r_rs1      <= '0;
         r_zimm     <= 5'd0;
         r_rd       <= 5'd0;
         r_pc       <= '0;
         r_old      <= '0;
         r_wdata    <= '0;
         r_redir_pc <= '0;
         r_is_csr   <= 1'b0;
         r_is_trap  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  r_funct3   <= bus.in_funct3;
                  r_addr     <= bus.in_csr_addr;
                  r_rs1      <= bus.in_rs1_data;
                  r_zimm     <= bus.in_zimm;
                  r_rd       <= bus.in_rd;
                  r_pc       <= bus.in_pc;
                  // Clear results so traps/EBREAK report zero, not stale data
                  r_old      <= '0;
                  r_wdata    <= '0;
                  r_redir_pc <= '0;
                  r_is_csr   <= is_csr_op(bus.in_funct3);
                  r_is_trap  <= w_is_priv &&
                                (bus.in_csr_addr == CSR_AW'(c_sys_ecall) ||
                                 bus.in_csr_addr == CSR_AW'(c_sys_mret));
               end
            end
            ST_CSR_RD: begin
               r_old <= bus.csr_rdata;
               if (w_alu_wr_need)
                  r_wdata <= w_alu_new;
            end
            // csr_upc is the trap vector during ECALL and MEPC during MRET
            ST_TRAP_E, ST_TRAP_M: r_redir_pc <= bus.csr_upc;
            default: ;
         endcase
      end
   end

`ifdef CSR_EBREAK_HALT_EN
   logic r_halt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_halt <= 1'b0;
      else if (w_state_next == ST_BRK)
         r_halt <= 1'b1;
   end

   assign halt = r_halt;
`endif

   // ------------------------------------------------------------ outputs
   assign bus.in_ready    = (r_state == ST_IDLE);
   assign bus.csr_ctrl    = r_csr_ctrl;
   assign bus.csr_addr    = r_addr;
   assign bus.csr_wdata   = r_wdata;
   assign bus.csr_pc      = r_pc;
   assign bus.csr_wen     = r_csr_wen;
   assign bus.out_valid   = (r_state == ST_DONE);
   assign bus.rd_wen      = (r_state == ST_DONE) && r_is_csr && (r_rd != 5'd0);
   assign bus.rd_data     = r_old;
   assign bus.redir_valid = (r_state == ST_DONE) && r_is_trap;
   assign bus.redir_pc    = r_redir_pc;

endmodule
`default_nettype wire

// File: doc/csr_access_ctrl.md
Name: csr_access_ctrl

Overview:
- Initiator side of the CSR file interface, sitting in EXU between the IDU handshake and the WBU/IFU.
- Sequences SYSTEM-opcode instructions (CSRRW/S/C and their immediate forms, ECALL, MRET, EBREAK) into CSR file transactions: `csr_ctrl`, `csr_addr`, `csr_wdata`, `csr_pc`, and a single-cycle `csr_wen` write strobe.
- Returns the old CSR value for rd writeback and a PC redirect for traps and returns.

Parameters:
- XLEN, 32, data/PC width
- CSR_AW, 12, CSR address width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- in_valid  in  1  IDU presents a SYSTEM instruction
- in_ready  out  1  block accepts instruction (high only in IDLE)
- in_funct3  in  3  instruction funct3
- in_csr_addr  in  12  instruction[31:20]
- in_rs1_data  in  XLEN  rs1 value
- in_zimm  in  5  rs1 field, used as immediate
- in_rd  in  5  destination register
- in_pc  in  XLEN  instruction PC
- csr_ctrl  out  3  000 NONE, 001 MRET, 010 ECALL, 011 EBREAK, 100 CSRW
- csr_addr  out  12  CSR address
- csr_wdata  out  XLEN  CSR write data
- csr_pc  out  XLEN  PC sent to CSR file (captured into MEPC on ECALL)
- csr_wen  out  1  one-cycle write strobe
- csr_rdata  in  XLEN  combinational read of csr_addr
- csr_upc  in  XLEN  combinational trap/return target
- out_valid  out  1  result ready for WBU
- out_ready  in  1  WBU accepts
- rd_wen  out  1  write rd
- rd_data  out  XLEN  old CSR value
- redir_valid  out  1  PC redirect valid; asserted together with out_valid
- redir_pc  out  XLEN  redirect target

Behaviour:
- Reset: state IDLE. All outputs 0, except in_ready=1.
- FSM states:
  - IDLE: in_ready=1. On in_valid, latch all in_* fields. funct3 000 dispatches on in_csr_addr: 0x000 → TRAP_E (ECALL), 0x302 → TRAP_M (MRET), 0x001 → BRK (EBREAK). Any other funct3 → CSR_RD.
  - CSR_RD: csr_ctrl=NONE, csr_addr=latched address. Sample csr_rdata into old. Compute new:
    - RW: src
    - RS: old|src
    - RC: old&~src
    - src = rs1_data for funct3[2]=0; zero-extended zimm for funct3[2]=1.
    - → CSR_WR if a write is needed, else DONE.
    - RS/RC with zimm=0, or with rs1 index=0 (carried as in_zimm), perform no write.
  - CSR_WR: csr_ctrl=CSRW, csr_wdata=new, csr_wen=1 for exactly this cycle → DONE.
  - TRAP_E: csr_ctrl=ECALL, csr_pc=latched pc, csr_wen=1. Capture csr_upc (MTVEC) into redir_pc → DONE with redirect.
  - TRAP_M: csr_ctrl=MRET, csr_wen=0. Capture csr_upc (MEPC) → DONE with redirect.
  - BRK: see Optional Feature.
  - DONE: out_valid=1. rd_wen=1 only for CSR ops with rd≠0. rd_data=old. Hold all values until out_valid&&out_ready → IDLE.
- Latency, accept to out_valid:
  - CSR write: 3 cycles.
  - CSR read-only: 2 cycles.
  - ECALL/MRET: 2 cycles.
- Back-to-back: IDLE is re-entered after the handshake. No overlap; in_ready is low outside IDLE.
- Register `csr_ctrl`/`csr_wen` so there are no glitches. A strobe never lasts more than one cycle.
- Unknown CSR addresses are passed through unchanged; the CSR file resolves them.
- rst_n low mid-sequence returns to IDLE immediately. Any pending `csr_wen` is dropped.

Optional Feature:
- CSR_EBREAK_HALT_EN defined:
  - BRK drives csr_ctrl=EBREAK for one cycle and asserts output `halt` (extra 1-bit port), which stays set until reset.
  - The FSM stays in HALT with in_ready=0.
- Undefined:
  - No `halt` port.
  - BRK drives csr_ctrl=EBREAK for one cycle with csr_wen=0 → DONE with no rd write and no redirect.

Decomposition:
- Shared package: csr_ctrl encodings (NONE/MRET/ECALL/EBREAK/CSRW), funct3 codes, FSM state enum, CSR address constants 0x300/0x305/0x341/0x342.
- Sub-module csr_alu: purely combinational RW/RS/RC compute plus the write-needed flag.

Test Plan:
- CSRRW x5, mtvec(0x305), rs1=0x80000100 → csr_wen=1 for one cycle with csr_wdata=0x80000100; out_valid at cycle 3; rd_data=old value.
- CSRRS x6, mcause, rs1 index=0 → no csr_wen; out_valid at cycle 2; rd_data=0x0000000b (after ECALL).
- CSRRCI mstatus, zimm=0x8 → csr_rdata=0x1800; csr_wdata=0x1800.
- ECALL at pc=0x80000040 with mtvec=0x80000100 → csr_ctrl=ECALL, csr_pc=0x80000040, csr_wen pulse; redir_pc=0x80000100.
- MRET with mepc=0x80000040 → csr_wen=0; redir_pc=0x80000040. Holding out_ready=0 for 4 cycles keeps outputs stable; in_ready=0 throughout.
- Reset pulse during CSR_WR → no csr_wen seen after rst_n falls; in_ready=1 after release; EBREAK → halt=1 with macro, plain completion without it.
